// File: rtl/alu_mc.sv
// Handshaked ALU: single-cycle ops return after one registered cycle, while mul/divu/remu
// run an iterative shift-add / restoring-divide engine for WIDTH cycles.
module alu_mc #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inp_a,
    input  logic [WIDTH-1:0] inp_b,
    input  logic [3:0]       opc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SLTU = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_SLT  = 4'hA;
    localparam logic [3:0] OP_MUL  = 4'hB;
    localparam logic [3:0] OP_DIVU = 4'hC;
    localparam logic [3:0] OP_REMU = 4'hD;

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
    localparam logic [SHW:0]     CNT_W   = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0]     CNT_ONE = (SHW + 1)'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic             accept, is_multi;
    logic [SHW:0]     cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] acc, qr, bq;
    logic [WIDTH-1:0] acc_nx, qr_nx, bq_nx, mc_res;
    logic [WIDTH:0]   rem_sh, rem_dif;
    logic             rem_ge;
    logic [WIDTH:0]   sum, dif;
    logic             shift_big;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;

    assign is_multi  = (opc == OP_MUL) || (opc == OP_DIVU) || (opc == OP_REMU);
    assign out_valid = (state == DONE);

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        in_ready = (state == IDLE) || ((state == DONE) && out_ready);
        accept   = in_valid && in_ready;
        case (state)
            IDLE:    if (accept) state_nx = is_multi ? BUSY : DONE;
            BUSY:    if (cnt == CNT_ONE) state_nx = DONE;
            DONE:    if (out_ready) state_nx = accept ? (is_multi ? BUSY : DONE) : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign sum       = {1'b0, inp_a} + {1'b0, inp_b};
    assign dif       = {1'b0, inp_a} + {1'b0, ~inp_b} + {{WIDTH{1'b0}}, 1'b1};
    assign shift_big = (inp_b >= W_VAL);

    always_comb begin
        sc_res = '1;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        case (opc)
            OP_ADD: begin
                sc_res = sum[MSB:0];
                sc_c   = sum[WIDTH];
                sc_v   = (inp_a[MSB] == inp_b[MSB]) && (sum[MSB] != inp_a[MSB]);
            end
            OP_SUB: begin
                // carry here is the inverted borrow of a - b
                sc_res = dif[MSB:0];
                sc_c   = dif[WIDTH];
                sc_v   = (inp_a[MSB] != inp_b[MSB]) && (dif[MSB] != inp_a[MSB]);
            end
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (inp_a < inp_b)};
            OP_OR:   sc_res = inp_a | inp_b;
            OP_AND:  sc_res = inp_a & inp_b;
            OP_SLL:  sc_res = shift_big ? '0 : (inp_a << inp_b[SHW-1:0]);
            OP_SRL:  sc_res = shift_big ? '0 : (inp_a >> inp_b[SHW-1:0]);
            OP_SRA:  sc_res = shift_big ? {WIDTH{inp_a[MSB]}}
                                        : WIDTH'($signed(inp_a) >>> inp_b[SHW-1:0]);
            OP_XOR:  sc_res = inp_a ^ inp_b;
            OP_NOR:  sc_res = ~(inp_a | inp_b);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(inp_a) < $signed(inp_b))};
            default: sc_res = '1;
        endcase
    end

    // One engine step: mul keeps multiplier in qr and shifted multiplicand in bq;
    // div shifts the dividend out of qr into the partial remainder acc while quotient bits shift in.
    assign rem_sh  = {acc, qr[MSB]};
    assign rem_dif = rem_sh - {1'b0, bq};
    assign rem_ge  = (rem_sh >= {1'b0, bq});

    always_comb begin
        acc_nx = acc;
        qr_nx  = qr;
        bq_nx  = bq;
        if (op_q == OP_MUL) begin
            acc_nx = qr[0] ? (acc + bq) : acc;
            qr_nx  = qr >> 1;
            bq_nx  = bq << 1;
        end else begin
            acc_nx = rem_ge ? rem_dif[MSB:0] : rem_sh[MSB:0];
            qr_nx  = {qr[MSB-1:0], rem_ge};
        end
        mc_res = (op_q == OP_DIVU) ? qr_nx : acc_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            op_q    <= '0;
            acc     <= '0;
            qr      <= '0;
            bq      <= '0;
            res     <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            flag_dz <= 1'b0;
        end else if (accept) begin
            op_q <= opc;
            if (is_multi) begin
                cnt <= CNT_W;
                acc <= '0;
                qr  <= (opc == OP_MUL) ? inp_b : inp_a;
                bq  <= (opc == OP_MUL) ? inp_a : inp_b;
            end else begin
                res     <= sc_res;
                flag_z  <= (sc_res == '0);
                flag_c  <= sc_c;
                flag_v  <= sc_v;
                flag_dz <= 1'b0;
            end
        end else if (state == BUSY) begin
            cnt <= cnt - CNT_ONE;
            acc <= acc_nx;
            qr  <= qr_nx;
            bq  <= bq_nx;
            if (cnt == CNT_ONE) begin
                // a zero divisor naturally yields all-ones quotient and remainder == A
                res     <= mc_res;
                flag_z  <= (mc_res == '0);
                flag_c  <= 1'b0;
                flag_v  <= 1'b0;
                flag_dz <= (op_q != OP_MUL) && (bq == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=16 and WIDTH=32; expected results are queued at issue
// time and compared by a monitor when the DUT hands a result over.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        sel;
    logic [31:0] inp_a, inp_b;
    logic [3:0]  opc;

    logic        in_ready16, out_valid16, z16, c16, v16, dz16;
    logic [15:0] res16;
    logic        in_ready32, out_valid32, z32, c32, v32, dz32;
    logic [31:0] res32;

    logic        obs_valid, obs_in_ready;
    logic [31:0] obs_res;
    logic [3:0]  obs_flags;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(in_ready16),
        .inp_a(inp_a[15:0]), .inp_b(inp_b[15:0]), .opc(opc),
        .out_valid(out_valid16), .out_ready(out_ready), .res(res16),
        .flag_z(z16), .flag_c(c16), .flag_v(v16), .flag_dz(dz16)
    );

    alu_mc #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(in_ready32),
        .inp_a(inp_a), .inp_b(inp_b), .opc(opc),
        .out_valid(out_valid32), .out_ready(out_ready), .res(res32),
        .flag_z(z32), .flag_c(c32), .flag_v(v32), .flag_dz(dz32)
    );

    assign obs_valid    = sel ? out_valid32 : out_valid16;
    assign obs_in_ready = sel ? in_ready32 : in_ready16;
    assign obs_res      = sel ? res32 : {16'h0, res16};
    assign obs_flags    = sel ? {z32, c32, v32, dz32} : {z16, c16, v16, dz16};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && obs_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(obs_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.tag, "_res"}, obs_res, e.res);
                check({e.tag, "_flags"}, 32'(obs_flags), 32'(e.flags));
            end
        end
    end

    // flags argument order is {z, c, v, dz}
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [3:0] ef, input int elat,
                         input string tag);
        exp_t e;
        int   waited;
        int   lat;
        logic busy_ready;
        waited = 0;
        while (obs_in_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #2;
            waited++;
        end
        if (waited >= 100) check({tag, "_ready_timeout"}, 32'(obs_in_ready), 32'd1);
        opc      = op;
        inp_a    = a;
        inp_b    = b;
        in_valid = 1'b1;
        e.res    = er;
        e.flags  = ef;
        e.tag    = tag;
        sb.push_back(e);
        @(posedge clk); #2;
        in_valid   = 1'b0;
        inp_a      = $urandom;
        inp_b      = $urandom;
        opc        = 4'($urandom);
        lat        = 0;
        busy_ready = 1'b0;
        while (obs_valid !== 1'b1 && lat < 200) begin
            if (obs_in_ready === 1'b1) busy_ready = 1'b1;
            @(posedge clk); #2;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        if (elat > 0) check({tag, "_busy_in_ready"}, 32'(busy_ready), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        exp_t e;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = 1'b0;
        inp_a     = '0;
        inp_b     = '0;
        opc       = '0;
        #1 rst_n  = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        check("reset_valid", 32'(obs_valid), 32'd0);
        check("reset_res", obs_res, 32'd0);
        check("reset_flags", 32'(obs_flags), 32'd0);
        rst_n = 1'b1;
        #1 check("reset_in_ready", 32'(obs_in_ready), 32'd1);
        @(posedge clk); #2;

        // WIDTH=16 single-cycle ops
        issue(4'h0, 32'h7FFF, 32'h0001, 32'h8000, 4'b0010, 0, "w16_add_ovf");
        issue(4'h1, 32'h0005, 32'h0005, 32'h0000, 4'b1100, 0, "w16_sub_zero");
        issue(4'h0, 32'hFFFF, 32'h0001, 32'h0000, 4'b1100, 0, "w16_add_carry");
        issue(4'h1, 32'h0000, 32'h0001, 32'hFFFF, 4'b0000, 0, "w16_sub_borrow");
        issue(4'h1, 32'h8000, 32'h0001, 32'h7FFF, 4'b0110, 0, "w16_sub_ovf");
        issue(4'h5, 32'h0001, 32'd20,   32'h0000, 4'b1000, 0, "w16_sll_big");
        issue(4'h5, 32'h0003, 32'd4,    32'h0030, 4'b0000, 0, "w16_sll4");
        issue(4'h7, 32'h8000, 32'd4,    32'hF800, 4'b0000, 0, "w16_sra4");
        issue(4'h7, 32'h8000, 32'd16,   32'hFFFF, 4'b0000, 0, "w16_sra_big");
        issue(4'h6, 32'h8000, 32'd4,    32'h0800, 4'b0000, 0, "w16_srl4");
        issue(4'h6, 32'h8000, 32'd16,   32'h0000, 4'b1000, 0, "w16_srl_big");
        issue(4'hA, 32'hFFFF, 32'h0001, 32'h0001, 4'b0000, 0, "w16_slt");
        issue(4'h2, 32'hFFFF, 32'h0001, 32'h0000, 4'b1000, 0, "w16_sltu");
        issue(4'h3, 32'hF0F0, 32'h0F0F, 32'hFFFF, 4'b0000, 0, "w16_or");
        issue(4'h4, 32'hF0F0, 32'h0FF0, 32'h00F0, 4'b0000, 0, "w16_and");
        issue(4'h8, 32'hAAAA, 32'hFFFF, 32'h5555, 4'b0000, 0, "w16_xor");
        issue(4'h9, 32'h1234, 32'h4321, 32'hACCA, 4'b0000, 0, "w16_nor");
        issue(4'hE, 32'h0000, 32'h0000, 32'hFFFF, 4'b0000, 0, "w16_opc14");
        issue(4'hF, 32'h1234, 32'h5678, 32'hFFFF, 4'b0000, 0, "w16_opc15");

        // WIDTH=16 multi-cycle ops
        issue(4'hB, 32'h0123, 32'h0010, 32'h1230, 4'b0000, 16, "w16_mul");
        issue(4'hB, 32'hFFFF, 32'hFFFF, 32'h0001, 4'b0000, 16, "w16_mul_ones");
        issue(4'hC, 32'd100,  32'd7,    32'd14,   4'b0000, 16, "w16_divu");
        issue(4'hD, 32'd100,  32'd7,    32'd2,    4'b0000, 16, "w16_remu");
        issue(4'hC, 32'h1234, 32'h0000, 32'hFFFF, 4'b0001, 16, "w16_divu_dz");
        issue(4'hD, 32'h1234, 32'h0000, 32'h1234, 4'b0001, 16, "w16_remu_dz");
        issue(4'hD, 32'h0006, 32'h0003, 32'h0000, 4'b1000, 16, "w16_remu_zero");

        // backpressure: result held while out_ready is low, pending op refused
        @(posedge clk); #2;
        out_ready = 1'b0;
        opc       = 4'h0;
        inp_a     = 32'd3;
        inp_b     = 32'd4;
        in_valid  = 1'b1;
        e.res = 32'd7; e.flags = 4'b0000; e.tag = "w16_bp_first";
        sb.push_back(e);
        @(posedge clk); #2;
        inp_a = 32'd1;
        inp_b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            check("w16_bp_valid_ready", 32'({obs_valid, obs_in_ready}), 32'b10);
            check("w16_bp_hold", {obs_res[27:0], obs_flags}, {28'd7, 4'b0000});
            @(posedge clk); #2;
        end
        e.res = 32'd2; e.flags = 4'b0000; e.tag = "w16_bp_second";
        sb.push_back(e);
        out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        check("w16_bp_b2b_valid", 32'(obs_valid), 32'd1);
        @(posedge clk); #2;

        // reset in BUSY cycle 7 of a divu discards the op
        check("w16_pre_rst_idle", 32'(obs_in_ready), 32'd1);
        opc      = 4'hC;
        inp_a    = 32'hFFFF;
        inp_b    = 32'd3;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        check("w16_busy7_in_ready", 32'(obs_in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("w16_rst_valid", 32'(obs_valid), 32'd0);
        check("w16_rst_res", obs_res, 32'd0);
        check("w16_rst_flags", 32'(obs_flags), 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        #1 check("w16_rst_in_ready", 32'(obs_in_ready), 32'd1);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            if (obs_valid === 1'b1) vcount++;
        end
        check("w16_rst_no_stale", 32'(vcount), 32'd0);

        // WIDTH=32 repeat of the add/sub and mul cases
        sel = 1'b1;
        #1;
        issue(4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0010, 0, "w32_add_ovf");
        issue(4'h1, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1100, 0, "w32_sub_zero");
        issue(4'h7, 32'h8000_0000, 32'd20,        32'hFFFF_F800, 4'b0000, 0, "w32_sra20");
        issue(4'hB, 32'h0000_0123, 32'h0000_0010, 32'h0000_1230, 4'b0000, 32, "w32_mul");
        issue(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 32, "w32_mul_ones");
        issue(4'hC, 32'd100000,    32'd7,         32'd14285,     4'b0000, 32, "w32_divu");

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
